// File: rtl/lu_pkg.sv
// Shared definitions for the bit-serial logic unit sequencer: operation codes,
// operation count and the sequencer state type.
package lu_pkg;

    localparam int LU_OPS = 7;

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_NONE = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } lu_state_e;

endpackage

// File: rtl/lu_sequencer_next_op_finder.sv
// Finds the next enabled operation strictly above the current one, or the
// lowest enabled operation when start_mode is set.
module next_op_finder
    import lu_pkg::*;
(
    input  logic [LU_OPS-1:0] mask,
    input  logic [2:0]        op,
    input  logic              start_mode,
    output logic [2:0]        next_op,
    output logic              none
);

    logic [LU_OPS-1:0] cand;

    for (genvar k = 0; k < LU_OPS; k++) begin : g_cand
        assign cand[k] = mask[k] & (start_mode | (3'(k) > op));
    end

    always_comb begin
        next_op = OP_NONE;
        none    = 1'b0;
        casez (cand)
            7'b??????1: next_op = OP_NOT;
            7'b?????10: next_op = OP_AND;
            7'b????100: next_op = OP_NAND;
            7'b???1000: next_op = OP_XOR;
            7'b??10000: next_op = OP_XNOR;
            7'b?100000: next_op = OP_OR;
            7'b1000000: next_op = OP_NOR;
            default:    none    = 1'b1;
        endcase
    end

endmodule

// File: rtl/lu_sequencer.sv
// Drives a 1-bit logic unit bit-serially over every enabled operation and
// collects the results into one word-wide result bus.
//
// state | meaning
// IDLE  | waiting for start; drive lines parked at OP_NONE
// RUN   | one operand bit pair per cycle, capturing lu_s each cycle
// DONE  | one-cycle done pulse, result stable
module lu_sequencer
    import lu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [WIDTH-1:0]        op_a,
    input  logic [WIDTH-1:0]        op_b,
    input  logic [LU_OPS-1:0]       op_mask,
    output logic                    busy,
    output logic                    done,
    output logic [LU_OPS*WIDTH-1:0] result,
    output logic                    lu_a,
    output logic                    lu_b,
    output logic [2:0]              lu_sel,
    input  logic                    lu_s
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW = LU_OPS * WIDTH;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    lu_state_e         state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [IW-1:0]     bit_idx_q, bit_idx_d, idx_inc;
    logic [WIDTH-1:0]  lat_a_q, lat_a_d, lat_b_q, lat_b_d;
    logic [LU_OPS-1:0] lat_mask_q, lat_mask_d;
    logic [RW-1:0]     result_d, wr_sel, captured;
    logic              lu_a_d, lu_b_d;
    logic [2:0]        lu_sel_d;
    logic [2:0]        fnd_op;
    logic              fnd_none;
    logic              in_idle;

    assign in_idle = (state_q == IDLE);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign idx_inc = bit_idx_q + IW'(1);

    next_op_finder u_next_op_finder (
        .mask       (in_idle ? op_mask : lat_mask_q),
        .op         (op_q),
        .start_mode (in_idle),
        .next_op    (fnd_op),
        .none       (fnd_none)
    );

    // One-hot write strobe for the result bit addressed by the current (op, i)
    for (genvar k = 0; k < LU_OPS; k++) begin : g_op
        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            assign wr_sel[k*WIDTH + j] = (state_q == RUN) && (op_q == 3'(k)) &&
                                         (bit_idx_q == IW'(j));
        end
    end

    assign captured = (result & ~wr_sel) | (wr_sel & {RW{lu_s}});

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        bit_idx_d  = bit_idx_q;
        lat_a_d    = lat_a_q;
        lat_b_d    = lat_b_q;
        lat_mask_d = lat_mask_q;
        result_d   = result;
        lu_a_d     = 1'b0;
        lu_b_d     = 1'b0;
        lu_sel_d   = OP_NONE;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    result_d = '0;
                    if (fnd_none) begin
                        state_d = DONE;
                    end else begin
                        lat_a_d    = op_a;
                        lat_b_d    = op_b;
                        lat_mask_d = op_mask;
                        op_d       = fnd_op;
                        bit_idx_d  = '0;
                        lu_a_d     = op_a[0];
                        lu_b_d     = op_b[0];
                        lu_sel_d   = fnd_op;
                        state_d    = RUN;
                    end
                end
            end
            RUN: begin
                result_d = captured;
                if (bit_idx_q != LAST_IDX) begin
                    bit_idx_d = idx_inc;
                    lu_a_d    = lat_a_q[idx_inc];
                    lu_b_d    = lat_b_q[idx_inc];
                    lu_sel_d  = op_q;
                end else begin
                    bit_idx_d = '0;
                    if (fnd_none) begin
                        state_d = DONE;
                    end else begin
                        op_d     = fnd_op;
                        lu_a_d   = lat_a_q[0];
                        lu_b_d   = lat_b_q[0];
                        lu_sel_d = fnd_op;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            bit_idx_q  <= '0;
            lat_a_q    <= '0;
            lat_b_q    <= '0;
            lat_mask_q <= '0;
            result     <= '0;
            lu_a       <= 1'b0;
            lu_b       <= 1'b0;
            lu_sel     <= OP_NONE;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            bit_idx_q  <= bit_idx_d;
            lat_a_q    <= lat_a_d;
            lat_b_q    <= lat_b_d;
            lat_mask_q <= lat_mask_d;
            result     <= result_d;
            lu_a       <= lu_a_d;
            lu_b       <= lu_b_d;
            lu_sel     <= lu_sel_d;
        end
    end

endmodule

// File: tb/tb_lu_sequencer.sv
// Directed bench for lu_sequencer with a behavioural 1-bit logic unit attached.
module tb_lu_sequencer;
    import lu_pkg::*;

    localparam int WIDTH = 4;

    logic                    clk, rst, start;
    logic [WIDTH-1:0]        op_a, op_b;
    logic [LU_OPS-1:0]       op_mask;
    logic                    busy, done;
    logic [LU_OPS*WIDTH-1:0] result;
    logic                    lu_a, lu_b, lu_s;
    logic [2:0]              lu_sel;

    int          n_vec = 0;
    int          n_err = 0;
    int          edges;
    int          busy_low;
    logic [23:0] sel_seq;

    lu_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_a    (op_a),
        .op_b    (op_b),
        .op_mask (op_mask),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .lu_a    (lu_a),
        .lu_b    (lu_b),
        .lu_sel  (lu_sel),
        .lu_s    (lu_s)
    );

    always_comb begin
        lu_s = 1'b0;
        case (lu_sel)
            OP_NOT:  lu_s = ~lu_a;
            OP_AND:  lu_s = lu_a & lu_b;
            OP_NAND: lu_s = ~(lu_a & lu_b);
            OP_XOR:  lu_s = lu_a ^ lu_b;
            OP_XNOR: lu_s = ~(lu_a ^ lu_b);
            OP_OR:   lu_s = lu_a | lu_b;
            OP_NOR:  lu_s = ~(lu_a | lu_b);
            default: lu_s = 1'b0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the request is taken at the next rising edge
    // and the task returns on the first falling edge after it.
    task automatic accept(input logic [3:0] a, input logic [3:0] b, input logic [6:0] m);
        start   = 1'b1;
        op_a    = a;
        op_b    = b;
        op_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // k0 is the index of the current falling edge counted from the accept.
    task automatic wait_done(input int k0);
        edges    = -1;
        busy_low = 0;
        sel_seq  = '0;
        for (int k = k0; k < k0 + 200; k++) begin
            if (done) begin
                edges = k - 1;
                break;
            end
            if (!busy) busy_low++;
            sel_seq = {sel_seq[20:0], lu_sel};
            @(negedge clk);
        end
    endtask

    initial begin
        int done_seen;
        rst     = 1'b1;
        start   = 1'b0;
        op_a    = '0;
        op_b    = '0;
        op_mask = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_lu_sel", 32'(lu_sel), 32'd7);
        check("rst_lu_a",   32'(lu_a),   32'd0);
        check("rst_lu_b",   32'(lu_b),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // all seven operations
        accept(4'b0101, 4'b0011, 7'h7F);
        check("t1_busy",   32'(busy),   32'd1);
        check("t1_sel0",   32'(lu_sel), 32'd0);
        check("t1_a0",     32'(lu_a),   32'd1);
        check("t1_b0",     32'(lu_b),   32'd1);
        wait_done(1);
        check("t1_edges",  32'(edges),    32'd28);
        check("t1_busyhi", 32'(busy_low), 32'd0);
        check("t1_busy_at_done", 32'(busy), 32'd0);
        check("t1_result", 32'(result), 32'h8796E1A);
        check("t1_sel_at_done", 32'(lu_sel), 32'd7);
        @(negedge clk);
        check("t1_done_pulse", 32'(done),   32'd0);
        check("t1_hold",       32'(result), 32'h8796E1A);

        // AND and XOR only
        accept(4'b0101, 4'b0011, 7'b0001010);
        wait_done(1);
        check("t2_edges",  32'(edges),   32'd8);
        check("t2_selseq", 32'(sel_seq), 32'h2496DB);
        check("t2_result", 32'(result),  32'h0006010);
        @(negedge clk);

        // empty mask
        accept(4'b1111, 4'b1111, 7'h00);
        wait_done(1);
        check("t3_edges",  32'(edges),    32'd0);
        check("t3_busy",   32'(busy_low + 32'(busy)), 32'd0);
        check("t3_result", 32'(result),   32'd0);
        check("t3_lu_sel", 32'(lu_sel),   32'd7);
        @(negedge clk);
        check("t3_done_pulse", 32'(done), 32'd0);

        // start during RUN is ignored; start in first IDLE cycle is accepted
        accept(4'b0101, 4'b0011, 7'b0001010);
        @(negedge clk);
        @(negedge clk);
        start   = 1'b1;
        op_a    = 4'b1111;
        op_b    = 4'b1111;
        op_mask = 7'h7F;
        @(negedge clk);
        start = 1'b0;
        wait_done(4);
        check("t4_edges",  32'(edges),  32'd8);
        check("t4_result", 32'(result), 32'h0006010);
        @(negedge clk);
        check("t4_idle_done", 32'(done), 32'd0);
        accept(4'b1100, 4'b1010, 7'b0100000);
        check("t4b_busy", 32'(busy),   32'd1);
        check("t4b_sel",  32'(lu_sel), 32'd5);
        check("t4b_a0",   32'(lu_a),   32'd0);
        wait_done(1);
        check("t4b_edges",  32'(edges),  32'd4);
        check("t4b_result", 32'(result), 32'h0E00000);
        @(negedge clk);

        // reset mid-run
        accept(4'b0101, 4'b0011, 7'h7F);
        repeat (4) @(negedge clk);
        check("t5_partial", 32'(result), 32'h000000A);
        rst = 1'b1;
        #1;
        check("t5_busy",   32'(busy),   32'd0);
        check("t5_result", 32'(result), 32'd0);
        check("t5_lu_sel", 32'(lu_sel), 32'd7);
        check("t5_lu_a",   32'(lu_a),   32'd0);
        check("t5_lu_b",   32'(lu_b),   32'd0);
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        rst = 1'b0;
        @(negedge clk);
        if (done) done_seen++;
        check("t5_no_done", 32'(done_seen), 32'd0);
        accept(4'b1100, 4'b1010, 7'b1000000);
        wait_done(1);
        check("t5_edges",  32'(edges),  32'd4);
        check("t5_result", 32'(result), 32'h1000000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
